// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Stalls the pipeline (hit=0) while a line refills or a store writes through.
module data_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic        hit,
  output logic [31:0] readData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWrData,
  input  logic        memReady,
  input  logic [31:0] memRdData,
  output logic [31:0] missCount,
  output logic [1:0]  o_dbg_state
);

  localparam int OFF  = $clog2(WORDS);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - 2 - OFF - IDX;

  // Memory handshake: a beat completes on a rising edge where memReq=1 and
  // memReady=1; memReq/memWe/memAddr/memWrData are held until that edge.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag  [LINES];
  logic [31:0]       r_data [LINES][WORDS];
  logic [OFF-1:0]    r_beat;
  logic [31:0]       r_miss_count;

  logic [OFF-1:0]    w_off;
  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic              w_match;
  logic              w_last_beat;
  logic              w_miss_start;
  logic              w_refill_beat;
  logic              w_write_done;
  logic              w_unused_ok;

  assign w_off       = addr[2+OFF-1:2];
  assign w_idx       = addr[2+OFF+IDX-1:2+OFF];
  assign w_tag       = addr[31:2+OFF+IDX];
  assign w_match     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last_beat = (r_beat == OFF'(WORDS - 1));
  assign w_unused_ok = &{1'b0, addr[1:0]};

  assign missCount   = r_miss_count;
  assign o_dbg_state = r_state;
  assign readData    = (MemRead && w_match) ? r_data[w_idx][w_off] : 32'h0;

  always_comb begin
    w_state_nxt   = r_state;
    hit           = 1'b1;
    memReq        = 1'b0;
    memWe         = 1'b0;
    memAddr       = 32'h0;
    memWrData     = 32'h0;
    w_miss_start  = 1'b0;
    w_refill_beat = 1'b0;
    w_write_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Read+write together is illegal; the write takes priority.
        if (MemWrite) begin
          hit         = 1'b0;
          w_state_nxt = S_WRITE;
        end else if (MemRead && !w_match) begin
          hit          = 1'b0;
          w_miss_start = 1'b1;
          w_state_nxt  = S_REFILL;
        end
      end
      S_REFILL: begin
        hit           = 1'b0;
        memReq        = 1'b1;
        memAddr       = {w_tag, w_idx, r_beat, 2'b00};
        w_refill_beat = memReady;
        if (memReady && w_last_beat) w_state_nxt = S_IDLE;
      end
      S_WRITE: begin
        memReq       = 1'b1;
        memWe        = 1'b1;
        memAddr      = {addr[31:2], 2'b00};
        memWrData    = writeData;
        hit          = memReady;
        w_write_done = memReady;
        if (memReady) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_beat       <= '0;
      r_miss_count <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      // The line is invalidated at miss time so a half-filled line never hits.
      if (w_miss_start) begin
        r_valid[w_idx] <= 1'b0;
        r_beat         <= '0;
        r_miss_count   <= r_miss_count + 32'd1;
      end
      if (w_refill_beat) begin
        r_beat <= r_beat + 1'b1;
        if (w_last_beat) r_valid[w_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_refill_beat) begin
      r_data[w_idx][r_beat] <= memRdData;
      if (w_last_beat) r_tag[w_idx] <= w_tag;
    end
    if (w_write_done && w_match) r_data[w_idx][w_off] <= writeData;
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: refill, hit, write-through, no-allocate,
// reset during refill and missCount wrap.
module tb_data_cache;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic        hit;
  logic [31:0] readData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWrData;
  logic        memReady;
  logic [31:0] memRdData;
  logic [31:0] missCount;
  logic [1:0]  o_dbg_state;

  data_cache #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .writeData(writeData), .hit(hit), .readData(readData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
    .memReady(memReady), .memRdData(memRdData), .missCount(missCount),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] beat_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  int          held_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // driver: one MEM-stage op, held until hit; delay=0 ties memReady high
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input int delay,
                       output int stall, output logic [31:0] rdata);
    int wait_cnt;
    bit done;
    wait_cnt = 0;
    done     = 1'b0;
    stall    = 0;
    rdata    = 32'h0;
    held_bad = 0;
    beat_q.delete();
    MemRead = rd; MemWrite = wr; addr = a; writeData = wd;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      memReady = (delay == 0) ? 1'b1 : (memReq && wait_cnt >= delay);
      #1;
      memRdData = memReady ? mem_word(memAddr) : 32'h0;
      #1;
      if (memReq && memWe && (memAddr != {a[31:2], 2'b00} || memWrData != wd)) held_bad++;
      if (memReq && memReady) begin
        if (memWe) begin
          bmem[memAddr] = memWrData;
          last_wr_addr  = memAddr;
          last_wr_data  = memWrData;
        end else begin
          beat_q.push_back(memAddr);
        end
        wait_cnt = 0;
      end else if (memReq) begin
        wait_cnt++;
      end
      if (hit) begin
        done  = 1'b1;
        rdata = readData;
      end else begin
        stall++;
      end
      @(negedge clk);
    end
    if (!done) check("op_timeout", 32'd0, 32'd1);
    MemRead = 1'b0; MemWrite = 1'b0; memReady = 1'b0; memRdData = 32'h0;
  endtask

  task automatic check_beats(input string tag);
    check({tag, "_nbeats"}, beat_q.size(), exp_q.size());
    while (exp_q.size() > 0 && beat_q.size() > 0)
      check({tag, "_beat"}, beat_q.pop_front(), exp_q.pop_front());
  endtask

  int          stall;
  logic [31:0] rdata;

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; addr = 32'h0;
    writeData = 32'h0; memReady = 1'b0; memRdData = 32'h0;
    last_wr_addr = 32'h0; last_wr_data = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_hit", {31'h0, hit}, 32'd1);
    check("rst_memReq", {31'h0, memReq}, 32'd0);
    check("rst_missCount", missCount, 32'd0);
    check("rst_state", {30'h0, o_dbg_state}, 32'd0);
    rst_n = 1'b1;

    // memReady while idle must be ignored
    memReady = 1'b1;
    @(negedge clk);
    check("idle_ready_state", {30'h0, o_dbg_state}, 32'd0);
    check("idle_readData", readData, 32'h0);
    memReady = 1'b0;

    // read miss at 0x40, memory always ready
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 0, stall, rdata);
    check("miss40_stall", stall, 32'd5);
    check("miss40_data", rdata, 32'hC0DE0040);
    check("miss40_count", missCount, 32'd1);
    exp_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    check_beats("miss40");

    do_op(1'b1, 1'b0, 32'h48, 32'h0, 0, stall, rdata);
    check("hit48_stall", stall, 32'd0);
    check("hit48_data", rdata, 32'hC0DE0048);
    check("hit48_count", missCount, 32'd1);

    // write-through hit with memReady after 3 wait cycles
    do_op(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 3, stall, rdata);
    check("wr44_stall", stall, 32'd4);
    check("wr44_held", held_bad, 32'd0);
    check("wr44_addr", last_wr_addr, 32'h44);
    check("wr44_data", last_wr_data, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 32'h44, 32'h0, 0, stall, rdata);
    check("rd44_stall", stall, 32'd0);
    check("rd44_data", rdata, 32'hDEADBEEF);

    // write to absent line: no allocation
    do_op(1'b0, 1'b1, 32'h1044, 32'h12345678, 0, stall, rdata);
    check("wr1044_stall", stall, 32'd1);
    check("wr1044_addr", last_wr_addr, 32'h1044);
    check("wr1044_data", last_wr_data, 32'h12345678);
    do_op(1'b1, 1'b0, 32'h1044, 32'h0, 0, stall, rdata);
    check("rd1044_stall", stall, 32'd5);
    check("rd1044_data", rdata, 32'h12345678);
    check("rd1044_count", missCount, 32'd2);
    do_op(1'b1, 1'b0, 32'h44, 32'h0, 0, stall, rdata);
    check("evict44_stall", stall, 32'd5);
    check("evict44_data", rdata, 32'hDEADBEEF);
    check("evict44_count", missCount, 32'd3);
    do_op(1'b1, 1'b0, 32'h40, 32'h0, 0, stall, rdata);
    check("rd40_stall", stall, 32'd0);
    check("rd40_data", rdata, 32'hC0DE0040);

    // reset after two refill beats
    MemRead = 1'b1; addr = 32'h2080; memReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      memRdData = mem_word(memAddr);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_state", {30'h0, o_dbg_state}, 32'd0);
    check("midrst_memReq", {31'h0, memReq}, 32'd0);
    check("midrst_count", missCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 32'h2080, 32'h0, 0, stall, rdata);
    check("rerefill_stall", stall, 32'd5);
    check("rerefill_data", rdata, 32'hC0DE2080);
    check("rerefill_count", missCount, 32'd1);
    exp_q = '{32'h2080, 32'h2084, 32'h2088, 32'h208C};
    check_beats("rerefill");

    // missCount wrap
    force dut.r_miss_count = 32'hFFFFFFFF;
    #1;
    release dut.r_miss_count;
    #1;
    check("preload_count", missCount, 32'hFFFFFFFF);
    do_op(1'b1, 1'b0, 32'h3000, 32'h0, 0, stall, rdata);
    check("wrap_count", missCount, 32'd0);
    check("wrap_data", rdata, 32'hC0DE3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
